// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
// The state encoding is decoded by hazard logic and benches.
package dmem_responder_pkg;
  localparam int WORD_W = 32;
  localparam int OFFS_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port storage: synchronous write, registered read.
// Contents are never cleared; only the read register resets.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage responder: stalls the pipeline for LATENCY cycles,
// then completes one load or store in a single response cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W  = WORD_W,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic              err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_wcnt;
  logic              r_op_rd;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req;
  logic              w_illegal;
  logic              w_legal;
  logic              w_idle;
  logic              w_go;
  logic              w_acc_rd;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused;

  assign w_req     = MemRead_i | MemWrite_i;
  assign w_illegal = w_req &
    ((addr_i[OFFS_W-1:0] != '0) | (MemRead_i & MemWrite_i));
  assign w_legal   = w_req & ~w_illegal;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_unused  = ^addr_i[31:AW+OFFS_W];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_legal)
          w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wcnt == 4'd0) w_next = ST_RESP;
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
      r_op_rd <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_legal) begin
        r_wcnt  <= WLOAD;
        r_op_rd <= MemRead_i;
        r_idx   <= addr_i[AW+OFFS_W-1:OFFS_W];
        r_wdata <= data_i;
      end else if (r_state == ST_WAIT && r_wcnt != 4'd0) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
    end
  end

  // The access fires on the edge entering RESP; with LATENCY=1
  // that edge leaves IDLE, so the live request is used directly.
  assign w_go     = ~rst_i & (w_next == ST_RESP) &
                    (r_state != ST_RESP);
  assign w_acc_rd = w_idle ? MemRead_i : r_op_rd;
  assign w_idx    = w_idle ? addr_i[AW+OFFS_W-1:OFFS_W] : r_idx;
  assign w_wdata  = w_idle ? data_i : r_wdata;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_go & ~w_acc_rd),
    .i_re    (w_go & w_acc_rd),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (data_o)
  );

  assign stall_o      = (w_idle & w_legal) | (r_state == ST_WAIT);
  assign resp_valid_o = (r_state == ST_RESP);
  assign err_o        = w_idle & w_illegal;
endmodule
